// File: rtl/mbledhesi_sekuencial.sv
// Multi-cycle adder/subtractor: adds or subtracts two WIDTH-bit operands,
// CHUNK bits per clock, with the carry rippling between chunks in a register.
//
// Ports:
//   Clock  - rising-edge clock
//   Reset  - asynchronous, active-high reset
//   Start  - request; accepted when Start and Ready are both 1 on an edge
//   SUB    - 0: A+B+CIN, 1: A-B-CIN (computed as A + ~B + ~CIN)
//   A, B   - operands, sampled on accept
//   CIN    - carry-in (add) or borrow-in (sub), sampled on accept
//   Ready  - idle and able to accept Start
//   Done   - one-cycle pulse when Shuma and the flags are updated
//   Shuma  - result, held until the next completion
//   COUT   - carry out of bit WIDTH-1 (in sub mode 1 = no borrow)
//   OVF    - signed two's-complement overflow
//   ZERO   - Shuma == 0
module mbledhesi_sekuencial #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic             SUB,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  output logic             Ready,
  output logic             Done,
  output logic [WIDTH-1:0] Shuma,
  output logic             COUT,
  output logic             OVF,
  output logic             ZERO
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [0:0]       state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] shadow_q;

  logic             accept;
  logic             last;
  int               base;
  logic [CHUNK-1:0] a_k;
  logic [CHUNK-1:0] b_k;
  logic [CHUNK:0]   sum_k;
  logic             msb_cin;
  logic [WIDTH-1:0] res_next;

  assign Ready  = (state_q == IDLE);
  assign accept = Start & Ready;
  assign last   = (cnt_q == LAST);

  always_comb begin
    base     = int'(cnt_q) * CHUNK;
    a_k      = a_q[base +: CHUNK];
    b_k      = b_q[base +: CHUNK];
    sum_k    = {1'b0, a_k}
             + {1'b0, b_k}
             + {{CHUNK{1'b0}}, carry_q};
    // Carry into the chunk MSB recovered from the
    // MSB sum bit; only meaningful on the last chunk.
    msb_cin  = sum_k[CHUNK-1]
             ^ a_k[CHUNK-1]
             ^ b_k[CHUNK-1];
    res_next = shadow_q;
    res_next[base +: CHUNK] = sum_k[CHUNK-1:0];
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      shadow_q <= '0;
      Done     <= 1'b0;
      Shuma    <= '0;
      COUT     <= 1'b0;
      OVF      <= 1'b0;
      ZERO     <= 1'b0;
    end else begin
      Done <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            a_q     <= A;
            b_q     <= SUB ? ~B : B;
            carry_q <= SUB ? ~CIN : CIN;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          shadow_q <= res_next;
          carry_q  <= sum_k[CHUNK];
          if (last) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            Done    <= 1'b1;
            Shuma   <= res_next;
            COUT    <= sum_k[CHUNK];
            OVF     <= msb_cin ^ sum_k[CHUNK];
            ZERO    <= (res_next == '0);
          end else begin
            cnt_q   <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mbledhesi_sekuencial.sv
// Self-checking bench for mbledhesi_sekuencial (WIDTH=8, CHUNK=2 and
// a WIDTH=8, CHUNK=8 single-cycle instance) against an arithmetic model.
module tb_mbledhesi_sekuencial;

  localparam int W = 8;
  localparam int C = 2;
  localparam int N = W / C;

  logic         Clock = 1'b0;
  logic         Reset = 1'b1;
  logic         Start = 1'b0;
  logic         start1 = 1'b0;
  logic         SUB = 1'b0;
  logic         CIN = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;

  logic         Ready, Done, COUT, OVF, ZERO;
  logic [W-1:0] Shuma;
  logic         ready1, done1, cout1, ovf1, zero1;
  logic [W-1:0] shuma1;

  int n_tests = 0;
  int n_fail  = 0;

  mbledhesi_sekuencial #(.WIDTH(W), .CHUNK(C)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start),
    .SUB(SUB), .A(A), .B(B), .CIN(CIN),
    .Ready(Ready), .Done(Done), .Shuma(Shuma),
    .COUT(COUT), .OVF(OVF), .ZERO(ZERO)
  );

  mbledhesi_sekuencial #(.WIDTH(W), .CHUNK(W)) dut1 (
    .Clock(Clock), .Reset(Reset), .Start(start1),
    .SUB(SUB), .A(A), .B(B), .CIN(CIN),
    .Ready(ready1), .Done(done1), .Shuma(shuma1),
    .COUT(cout1), .OVF(ovf1), .ZERO(zero1)
  );

  always #5 Clock = ~Clock;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h",
               tag, got, exp);
    end
  endtask

  // {cout, ovf, zero, result} from plain integer arithmetic
  function automatic logic [10:0] model(
    input logic [7:0] a, b,
    input logic sub, cin);
    int ur, sr, sa, sb, ci;
    logic [7:0] res;
    logic co, ov;
    sa = int'($signed(a));
    sb = int'($signed(b));
    ci = int'(cin);
    if (sub) begin
      ur = int'(a) - int'(b) - ci;
      sr = sa - sb - ci;
      co = (ur >= 0);
    end else begin
      ur = int'(a) + int'(b) + ci;
      sr = sa + sb + ci;
      co = (ur > 255);
    end
    res = 8'(ur);
    ov  = (sr > 127) || (sr < -128);
    return {co, ov, (res == 8'h00), res};
  endfunction

  task automatic do_op(input logic [7:0] a, b,
                       input logic sub, cin,
                       input bit noise);
    logic [10:0] e;
    logic [7:0]  prev;
    int n;
    e = model(a, b, sub, cin);
    @(negedge Clock);
    A = a; B = b; SUB = sub; CIN = cin;
    Start = 1'b1;
    prev = Shuma;
    chk("ready_idle", 32'(Ready), 32'd1);
    @(posedge Clock); #1;
    Start = 1'b0;
    n = 0;
    while (!Done && n < 3 * N) begin
      chk("ready_run", 32'(Ready), 32'd0);
      chk("hold", 32'(Shuma), 32'(prev));
      if (noise) begin
        Start = 1'b1;
        A = 8'($urandom);
        B = 8'($urandom);
        SUB = 1'($urandom);
        CIN = 1'($urandom);
      end
      @(posedge Clock); #1;
      n++;
    end
    Start = 1'b0;
    chk("latency", 32'(n), 32'(N));
    chk("shuma", 32'(Shuma), 32'(e[7:0]));
    chk("cout", 32'(COUT), 32'(e[10]));
    chk("ovf", 32'(OVF), 32'(e[9]));
    chk("zero", 32'(ZERO), 32'(e[8]));
    chk("ready_done", 32'(Ready), 32'd1);
    @(posedge Clock); #1;
    chk("done_pulse", 32'(Done), 32'd0);
  endtask

  initial begin
    int n;
    #12;
    chk("rst_ready", 32'(Ready), 32'd1);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_shuma", 32'(Shuma), 32'd0);
    chk("rst_flags", {29'd0, COUT, OVF, ZERO}, 32'd0);
    @(negedge Clock);
    Reset = 1'b0;

    do_op(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
    do_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    do_op(8'h05, 8'h07, 1'b1, 1'b0, 1'b0);
    do_op(8'h80, 8'h01, 1'b1, 1'b0, 1'b0);
    do_op(8'h12, 8'h34, 1'b0, 1'b1, 1'b1);
    do_op(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);

    // async reset in the middle of an operation
    @(negedge Clock);
    A = 8'h55; B = 8'h22; SUB = 1'b0; CIN = 1'b0;
    Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    @(posedge Clock);
    @(posedge Clock); #1;
    Reset = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(Ready), 32'd1);
    chk("mid_rst_done", 32'(Done), 32'd0);
    chk("mid_rst_shuma", 32'(Shuma), 32'd0);
    chk("mid_rst_flags", {29'd0, COUT, OVF, ZERO}, 32'd0);
    @(negedge Clock);
    Reset = 1'b0;
    repeat (6) begin
      @(posedge Clock); #1;
      chk("no_done", 32'(Done), 32'd0);
    end
    do_op(8'h55, 8'h22, 1'b0, 1'b0, 1'b0);

    // back-to-back: Start held across the Done cycle
    @(negedge Clock);
    A = 8'h10; B = 8'h20; SUB = 1'b0; CIN = 1'b0;
    Start = 1'b1;
    @(posedge Clock); #1;
    A = 8'h01; B = 8'h01;
    n = 0;
    while (!Done && n < 3 * N) begin
      @(posedge Clock); #1;
      n++;
    end
    chk("b2b_lat1", 32'(n), 32'(N));
    chk("b2b_res1", 32'(Shuma), 32'h30);
    chk("b2b_ready", 32'(Ready), 32'd1);
    @(posedge Clock); #1;
    Start = 1'b0;
    chk("b2b_busy", 32'(Ready), 32'd0);
    chk("b2b_hold", 32'(Shuma), 32'h30);
    n = 0;
    while (!Done && n < 3 * N) begin
      @(posedge Clock); #1;
      n++;
    end
    chk("b2b_lat2", 32'(n), 32'(N));
    chk("b2b_res2", 32'(Shuma), 32'h02);

    // single-chunk instance: Done one edge after accept
    @(negedge Clock);
    A = 8'h7F; B = 8'h01; SUB = 1'b0; CIN = 1'b0;
    start1 = 1'b1;
    chk("n1_ready", 32'(ready1), 32'd1);
    @(posedge Clock); #1;
    start1 = 1'b0;
    chk("n1_busy", 32'(ready1), 32'd0);
    chk("n1_early", 32'(done1), 32'd0);
    @(posedge Clock); #1;
    chk("n1_done", 32'(done1), 32'd1);
    chk("n1_shuma", 32'(shuma1), 32'h80);
    chk("n1_flags", {29'd0, cout1, ovf1, zero1}, 32'b010);
    @(posedge Clock); #1;
    chk("n1_pulse", 32'(done1), 32'd0);

    for (int i = 0; i < 40; i++) begin
      do_op(8'($urandom), 8'($urandom),
            1'($urandom), 1'($urandom),
            bit'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
